// File: rtl/event_scaler.sv
// Windowed per-channel event counter: each period tick snapshots all counts and streams them out.
// First beat one cycle after the tick; valid/ready readout, a tick that lands mid-readout is dropped and flagged.
module event_scaler #(
    parameter  int NCHAN  = 4,
    parameter  int WIDTH  = 24,
    localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ce_i,
    input  logic [NCHAN-1:0]  event_i,
    input  logic              period_tick_i,
    input  logic              clear_i,
    output logic [WIDTH-1:0]  scaler_dat_o,
    output logic [CHAN_W-1:0] scaler_chan_o,
    output logic              scaler_last_o,
    output logic              scaler_valid_o,
    input  logic              scaler_ready_i,
    output logic              overrun_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [CHAN_W-1:0]   r_chan;
    logic                r_overrun;
    logic [WIDTH-1:0]    r_acc  [NCHAN];
    logic [WIDTH-1:0]    r_hold [NCHAN];

    logic [WIDTH-1:0]    w_acc_sat [NCHAN];
    logic                w_accept;
    logic                w_last;
    logic                w_load;

    // Count including this cycle's event, stuck at all-ones once full.
    always_comb begin
        for (int n = 0; n < NCHAN; n++) begin
            w_acc_sat[n] = r_acc[n];
            if (ce_i && event_i[n] && !(&r_acc[n]))
                w_acc_sat[n] = r_acc[n] + WIDTH'(1);
        end
    end

    assign w_accept = (r_state == S_SEND) && scaler_ready_i;
    assign w_last   = (r_chan == CHAN_W'(NCHAN - 1));
    // A tick on the final accepted beat counts as a tick in idle.
    assign w_load   = period_tick_i && ((r_state == S_IDLE) || (w_accept && w_last));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_chan    <= '0;
            r_overrun <= 1'b0;
            for (int n = 0; n < NCHAN; n++) begin
                r_acc[n]  <= '0;
                r_hold[n] <= '0;
            end
        end else if (clear_i) begin
            r_state   <= S_IDLE;
            r_chan    <= '0;
            r_overrun <= 1'b0;
            for (int n = 0; n < NCHAN; n++) begin
                r_acc[n]  <= '0;
                r_hold[n] <= '0;
            end
        end else begin
            r_overrun <= period_tick_i && !w_load;
            for (int n = 0; n < NCHAN; n++)
                r_acc[n] <= period_tick_i ? '0 : w_acc_sat[n];
            if (w_load) begin
                for (int n = 0; n < NCHAN; n++)
                    r_hold[n] <= w_acc_sat[n];
                r_chan  <= '0;
                r_state <= S_SEND;
            end else if (w_accept) begin
                if (w_last)
                    r_state <= S_IDLE;
                else
                    r_chan <= r_chan + CHAN_W'(1);
            end
        end
    end

    assign scaler_valid_o = (r_state == S_SEND);
    assign scaler_dat_o   = r_hold[r_chan];
    assign scaler_chan_o  = r_chan;
    assign scaler_last_o  = w_last;
    assign overrun_o      = r_overrun;

endmodule

// File: tb/tb_event_scaler.sv
// Bench for event_scaler: a 24-bit and a 4-bit instance share stimulus and are checked against a queue-based model.
module tb_event_scaler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ce_i;
    logic [3:0]  event_i;
    logic        period_tick_i;
    logic        clear_i;
    logic        scaler_ready_i;

    logic [23:0] dat24;
    logic [1:0]  chan24;
    logic        last24, valid24, ovr24;
    logic [3:0]  dat4;
    logic [1:0]  chan4;
    logic        last4, valid4, ovr4;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    event_scaler #(.NCHAN(4), .WIDTH(24)) u_w24 (
        .clk_i(clk_i), .rst_ni(rst_ni), .ce_i(ce_i), .event_i(event_i),
        .period_tick_i(period_tick_i), .clear_i(clear_i),
        .scaler_dat_o(dat24), .scaler_chan_o(chan24), .scaler_last_o(last24),
        .scaler_valid_o(valid24), .scaler_ready_i(scaler_ready_i), .overrun_o(ovr24)
    );

    event_scaler #(.NCHAN(4), .WIDTH(4)) u_w4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .ce_i(ce_i), .event_i(event_i),
        .period_tick_i(period_tick_i), .clear_i(clear_i),
        .scaler_dat_o(dat4), .scaler_chan_o(chan4), .scaler_last_o(last4),
        .scaler_valid_o(valid4), .scaler_ready_i(scaler_ready_i), .overrun_o(ovr4)
    );

    // Reference: running window counts plus a queue of snapshot beats awaiting readout.
    typedef struct {
        int     chan;
        longint d24;
        longint d4;
    } beat_t;

    beat_t  q[$];
    longint acc24 [4];
    longint acc4  [4];
    bit     ovr_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovr_exp = 1'b0;
        for (int n = 0; n < 4; n++) begin
            acc24[n] = 0;
            acc4[n]  = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] ev, input logic tk, input logic ce,
                              input logic rdy, input logic clr);
        bit hs;
        beat_t b;
        hs = (q.size() > 0) && rdy;
        if (clr) begin
            model_reset();
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (ce && ev[n]) begin
                    if (acc24[n] < 64'hFF_FFFF) acc24[n]++;
                    if (acc4[n]  < 15)          acc4[n]++;
                end
            end
            if (hs) void'(q.pop_front());
            if (tk) begin
                if (q.size() == 0) begin
                    for (int n = 0; n < 4; n++) begin
                        b.chan = n;
                        b.d24  = acc24[n];
                        b.d4   = acc4[n];
                        q.push_back(b);
                    end
                    ovr_exp = 1'b0;
                end else begin
                    ovr_exp = 1'b1;
                end
                for (int n = 0; n < 4; n++) begin
                    acc24[n] = 0;
                    acc4[n]  = 0;
                end
            end else begin
                ovr_exp = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("valid24",   valid24, q.size() > 0);
        chk("valid4",    valid4,  q.size() > 0);
        chk("overrun24", ovr24,   ovr_exp);
        chk("overrun4",  ovr4,    ovr_exp);
        if (q.size() > 0) begin
            chk("chan24", chan24, q[0].chan);
            chk("chan4",  chan4,  q[0].chan);
            chk("last24", last24, q[0].chan == 3);
            chk("last4",  last4,  q[0].chan == 3);
            chk("dat24",  dat24,  q[0].d24);
            chk("dat4",   dat4,   q[0].d4);
        end
    endtask

    // Check outputs at the falling edge, then drive the next cycle's inputs.
    task automatic cyc(input logic [3:0] ev, input logic tk, input logic ce,
                       input logic rdy, input logic clr);
        check_all();
        event_i        = ev;
        period_tick_i  = tk;
        ce_i           = ce;
        scaler_ready_i = rdy;
        clear_i        = clr;
        model_step(ev, tk, ce, rdy, clr);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni = 1'b0; ce_i = 1'b0; event_i = '0; period_tick_i = 1'b0;
        clear_i = 1'b0; scaler_ready_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_valid", valid24, 0);
        chk("rst_dat",   dat24,   0);
        chk("rst_chan",  chan24,  0);
        chk("rst_last",  last24,  0);
        chk("rst_ovr",   ovr24,   0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Basic count: 10/0/3/7 on channels 0..3.
        for (int i = 0; i < 10; i++) cyc({i < 7, i < 3, 1'b0, 1'b1}, 0, 1, 1, 0);
        cyc(4'b0000, 1, 1, 1, 0);
        repeat (6) cyc(4'b0000, 0, 1, 1, 0);

        // Event in the tick cycle lands in the closing window; ce_i=0 blocks counting.
        repeat (2) cyc(4'b0010, 0, 1, 1, 0);
        cyc(4'b0010, 1, 1, 1, 0);
        repeat (5) cyc(4'b1111, 0, 0, 1, 0);
        cyc(4'b0000, 1, 1, 1, 0);
        repeat (5) cyc(4'b0000, 0, 1, 1, 0);

        // Saturation of the narrow instance.
        repeat (20) cyc(4'b0100, 0, 1, 1, 0);
        cyc(4'b0000, 1, 1, 1, 0);
        repeat (5) cyc(4'b0000, 0, 1, 1, 0);

        // Backpressure with an overrunning tick part way through.
        repeat (5) cyc(4'b1001, 0, 1, 1, 0);
        cyc(4'b0000, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc((i < 4) ? 4'b0001 : 4'b0010, i == 4, 1, 0, 0);
        repeat (6) cyc(4'b0010, 0, 1, 1, 0);
        cyc(4'b0000, 1, 1, 1, 0);
        repeat (5) cyc(4'b0000, 0, 1, 1, 0);

        // Tick coincident with the final accepted beat.
        cyc(4'b0001, 1, 1, 1, 0);
        repeat (3) cyc(4'b0100, 0, 1, 1, 0);
        cyc(4'b1000, 1, 1, 1, 0);
        repeat (6) cyc(4'b0000, 0, 1, 1, 0);

        // Clear wins over a simultaneous tick.
        repeat (3) cyc(4'b1111, 0, 1, 1, 0);
        cyc(4'b1111, 1, 1, 1, 1);
        repeat (2) cyc(4'b0000, 0, 1, 1, 0);
        cyc(4'b0000, 1, 1, 1, 0);
        repeat (5) cyc(4'b0000, 0, 1, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cyc(4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        repeat (6) cyc(4'b0000, 0, 1, 1, 0);

        // Asynchronous reset in the middle of a readout.
        repeat (4) cyc(4'b0110, 0, 1, 1, 0);
        cyc(4'b0000, 1, 1, 0, 0);
        cyc(4'b0000, 0, 1, 0, 0);
        check_all();
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_valid24", valid24, 0);
        chk("midrst_valid4",  valid4,  0);
        chk("midrst_dat24",   dat24,   0);
        chk("midrst_chan24",  chan24,  0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) cyc(4'b1000, 0, 1, 1, 0);
        cyc(4'b0000, 1, 1, 1, 0);
        repeat (6) cyc(4'b0000, 0, 1, 1, 0);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
